// File: rtl/d_seq.sv
// SD data-write sequencer: receives 8 blocks, runs the cipher engine, then sends
// them back block by block, checking the CRC-status token and card busy for each.
module d_seq #(
  parameter int STATUS_TO = 255,
  parameter int BUSY_TO   = 65535
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       istart,
  input  logic       iabort,
  input  logic       idat0,
  output logic       od_start,
  output logic       od_rst,
  input  logic       id_read_done,
  input  logic       id_write_done,
  input  logic       id_check_status,
  output logic       oproc_start,
  input  logic       iproc_done,
  output logic       obusy,
  output logic       odone,
  output logic       oerror,
  output logic [1:0] oerr_code
);

  localparam int CW = $clog2(BUSY_TO + 1);
  localparam logic [CW-1:0] STAT_LIM = CW'(STATUS_TO - 1);
  localparam logic [CW-1:0] BUSY_LIM = CW'(BUSY_TO - 1);

  typedef enum logic [2:0] {
    IDLE, RCV, PROC, SEND, STAT_WAIT, STAT_BITS, BUSY_WAIT, FINISH
  } state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] cnt;
  logic [2:0]    blk;
  logic [2:0]    tok;
  logic          abort_hit;
  logic          err_set;
  logic [1:0]    err_code_nxt;
  logic          od_start_d, oproc_start_d, od_rst_d, odone_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  assign abort_hit = iabort && (state != IDLE);
  assign obusy     = (state != IDLE);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) state <= IDLE;
    else      state <= nxt_state;
  end

  always_comb begin
    nxt_state    = state;
    err_set      = 1'b0;
    err_code_nxt = 2'b00;
    case (state)
      IDLE:      if (istart) nxt_state = RCV;
      RCV: begin
        if (id_read_done) nxt_state = PROC;
        // the driver's write_done is still stale for the first two cycles
        else if (id_write_done && cnt >= CW'(2)) begin
          err_set = 1'b1; err_code_nxt = 2'b01;
        end
      end
      PROC:      if (iproc_done) nxt_state = SEND;
      SEND:      if (id_check_status) nxt_state = STAT_WAIT;
      STAT_WAIT: begin
        if (!idat0) nxt_state = STAT_BITS;
        else if (cnt >= STAT_LIM) begin err_set = 1'b1; err_code_nxt = 2'b11; end
      end
      STAT_BITS: begin
        // 3 token bits, end bit, then 2 turnaround cycles
        if (cnt == CW'(5)) begin
          if (tok == 3'b010) nxt_state = BUSY_WAIT;
          else begin err_set = 1'b1; err_code_nxt = 2'b10; end
        end
      end
      BUSY_WAIT: begin
        if (idat0) nxt_state = (blk == 3'd7) ? FINISH : SEND;
        else if (cnt >= BUSY_LIM) begin err_set = 1'b1; err_code_nxt = 2'b11; end
      end
      FINISH: begin
        if (id_write_done) nxt_state = IDLE;
        else if (cnt >= STAT_LIM) begin err_set = 1'b1; err_code_nxt = 2'b11; end
      end
      default:   nxt_state = IDLE;
    endcase
    if (err_set) nxt_state = IDLE;
    if (abort_hit) begin
      nxt_state = IDLE;
      err_set   = 1'b0;
    end
  end

  always_comb begin
    od_start_d    = (state == IDLE && nxt_state == RCV) ||
                    (state == PROC && nxt_state == SEND) ||
                    (state == BUSY_WAIT && (nxt_state == SEND || nxt_state == FINISH));
    oproc_start_d = (state == RCV && nxt_state == PROC);
    od_rst_d      = abort_hit || err_set;
    odone_d       = (state == FINISH) && (nxt_state == IDLE) && !od_rst_d;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      od_start    <= 1'b0;
      oproc_start <= 1'b0;
      od_rst      <= 1'b0;
      odone       <= 1'b0;
      oerror      <= 1'b0;
      oerr_code   <= 2'b00;
      blk         <= 3'd0;
      cnt         <= '0;
      tok         <= 3'b000;
    end else begin
      od_start    <= od_start_d;
      oproc_start <= oproc_start_d;
      od_rst      <= od_rst_d;
      odone       <= odone_d;
      if (state == IDLE && nxt_state == RCV) begin
        oerror    <= 1'b0;
        oerr_code <= 2'b00;
        blk       <= 3'd0;
      end else if (err_set) begin
        oerror    <= 1'b1;
        oerr_code <= err_code_nxt;
      end
      if (state == BUSY_WAIT && (nxt_state == SEND || nxt_state == FINISH))
        blk <= blk + 3'd1;
      cnt <= (nxt_state != state) ? '0 : sat_inc(cnt);
      if (state == STAT_BITS && cnt < CW'(3))
        tok <= {tok[1:0], idat0};
    end
  end

endmodule

// File: tb/tb_d_seq.sv
// Scoreboard bench for d_seq: each transaction pushes its expected outcome and
// the monitor compares pulse counts and status when obusy falls.
module tb_d_seq;
  localparam int STATUS_TO = 16;
  localparam int BUSY_TO   = 40;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       istart = 1'b0, iabort = 1'b0, idat0 = 1'b1;
  logic       id_read_done = 1'b0, id_write_done = 1'b0, id_check_status = 1'b0;
  logic       iproc_done = 1'b0;
  logic       od_start, od_rst, oproc_start, obusy, odone, oerror;
  logic [1:0] oerr_code;

  d_seq #(.STATUS_TO(STATUS_TO), .BUSY_TO(BUSY_TO)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .iabort(iabort), .idat0(idat0),
    .od_start(od_start), .od_rst(od_rst), .id_read_done(id_read_done),
    .id_write_done(id_write_done), .id_check_status(id_check_status),
    .oproc_start(oproc_start), .iproc_done(iproc_done), .obusy(obusy),
    .odone(odone), .oerror(oerror), .oerr_code(oerr_code)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic       done;
    logic       err;
    logic [1:0] code;
    int         ns;
    int         np;
    int         nr;
    int         blk;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int n_start = 0, n_proc = 0, n_rst = 0, n_done = 0, dbl = 0, tidx = 0;
  logic busy_prev = 1'b0;
  logic p_start = 1'b0, p_proc = 1'b0, p_rst = 1'b0, p_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge iclk) begin
    exp_t e;
    if (od_start)    n_start++;
    if (oproc_start) n_proc++;
    if (od_rst)      n_rst++;
    if (odone)       n_done++;
    if ((od_start && p_start) || (oproc_start && p_proc) ||
        (od_rst && p_rst) || (odone && p_done)) dbl++;
    p_start = od_start; p_proc = oproc_start; p_rst = od_rst; p_done = odone;
    if (busy_prev && !obusy) begin
      if (sbq.size() == 0) begin
        check($sformatf("t%0d_sb_pop", tidx), 0, 1);
      end else begin
        e = sbq.pop_front();
        check($sformatf("t%0d_done", tidx), n_done, 32'(e.done));
        check($sformatf("t%0d_oerror", tidx), oerror, e.err);
        check($sformatf("t%0d_code", tidx), oerr_code, e.code);
        if (e.ns >= 0) check($sformatf("t%0d_n_start", tidx), n_start, e.ns);
        check($sformatf("t%0d_n_proc", tidx), n_proc, e.np);
        check($sformatf("t%0d_n_rst", tidx), n_rst, e.nr);
        if (e.blk >= 0) check($sformatf("t%0d_blk", tidx), dut.blk, e.blk);
      end
      tidx++;
      n_start = 0; n_proc = 0; n_rst = 0; n_done = 0;
    end
    busy_prev = obusy;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge iclk); #1; end
  endtask

  task automatic push(input logic d, input logic e, input logic [1:0] c,
                      input int ns, input int np, input int nr, input int b);
    exp_t x;
    x.done = d; x.err = e; x.code = c; x.ns = ns; x.np = np; x.nr = nr; x.blk = b;
    sbq.push_back(x);
  endtask

  task automatic pulse_start();
    istart = 1'b1; step(); istart = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (obusy && k < max) begin step(); k++; end
    check({tag, "_idle"}, obusy, 0);
  endtask

  task automatic rcv_proc(input int rd_delay);
    step(rd_delay - 1);
    id_read_done = 1'b1; step(); id_read_done = 1'b0;
    step(4);
    iproc_done = 1'b1; step(); iproc_done = 1'b0;
  endtask

  task automatic send_block(input logic [2:0] t, input int busy_n);
    step(2);
    id_check_status = 1'b1; step(); id_check_status = 1'b0;
    step();
    idat0 = 1'b0; step();
    idat0 = t[2]; step();
    idat0 = t[1]; step();
    idat0 = t[0]; step();
    idat0 = 1'b1; step();
    idat0 = 1'b0; step(busy_n);
    idat0 = 1'b1; step();
  endtask

  task automatic run_nominal(input string tag);
    push(1'b1, 1'b0, 2'b00, 10, 1, 0, -1);
    pulse_start();
    rcv_proc(100);
    for (int b = 0; b < 8; b++) send_block(3'b010, 20);
    step(3);
    id_write_done = 1'b1;
    wait_idle(tag, 10);
    id_write_done = 1'b0;
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    check("rst_od_start", od_start, 0);
    check("rst_od_rst", od_rst, 0);
    check("rst_oproc", oproc_start, 0);
    check("rst_odone", odone, 0);
    check("rst_oerror", oerror, 0);
    check("rst_obusy", obusy, 0);
    check("rst_code", oerr_code, 0);
    irst = 1'b0;
    step(2);

    run_nominal("nom1");

    // receive CRC failure
    push(1'b0, 1'b1, 2'b01, 1, 0, 1, 0);
    pulse_start();
    step(49);
    id_write_done = 1'b1;
    wait_idle("crc", 5);
    id_write_done = 1'b0;
    step(3);

    // write_done in the first two RCV cycles is ignored; abort afterwards
    push(1'b0, 1'b0, 2'b00, 1, 0, 1, -1);
    pulse_start();
    id_write_done = 1'b1; step(2); id_write_done = 1'b0;
    step();
    check("rcv_guard_busy", obusy, 1);
    iabort = 1'b1; step(); iabort = 1'b0;
    wait_idle("rcv_abort", 3);
    step(2);

    // bad token on the third block
    push(1'b0, 1'b1, 2'b10, 4, 1, 1, 2);
    pulse_start();
    rcv_proc(10);
    send_block(3'b010, 20);
    send_block(3'b010, 20);
    send_block(3'b101, 20);
    wait_idle("tok", 5);
    step(5);

    // abort coincident with iproc_done
    push(1'b0, 1'b0, 2'b00, 1, 1, 1, -1);
    pulse_start();
    step(9);
    id_read_done = 1'b1; step(); id_read_done = 1'b0;
    step(3);
    iproc_done = 1'b1; iabort = 1'b1; step(); iproc_done = 1'b0; iabort = 1'b0;
    wait_idle("abort", 3);
    step(3);

    // no CRC-status start bit
    push(1'b0, 1'b1, 2'b11, 2, 1, 1, 0);
    pulse_start();
    rcv_proc(10);
    step(2);
    id_check_status = 1'b1; step(); id_check_status = 1'b0;
    step(STATUS_TO - 1);
    check("stat_to_early", obusy, 1);
    wait_idle("stat_to", 5);
    step(3);

    // D0 stuck low after a good token
    push(1'b0, 1'b1, 2'b11, 2, 1, 1, 0);
    pulse_start();
    rcv_proc(10);
    step(2);
    id_check_status = 1'b1; step(); id_check_status = 1'b0;
    step();
    idat0 = 1'b0; step();
    idat0 = 1'b0; step();
    idat0 = 1'b1; step();
    idat0 = 1'b0; step();
    idat0 = 1'b1; step();
    idat0 = 1'b0;
    wait_idle("busy_to", BUSY_TO + 20);
    idat0 = 1'b1;
    step(3);

    // reset while in SEND, then a clean transaction
    push(1'b0, 1'b0, 2'b00, 5, 1, 0, -1);
    pulse_start();
    rcv_proc(10);
    for (int b = 0; b < 3; b++) send_block(3'b010, 20);
    step();
    irst = 1'b1; step();
    check("mid_rst_obusy", obusy, 0);
    check("mid_rst_od_start", od_start, 0);
    check("mid_rst_od_rst", od_rst, 0);
    check("mid_rst_blk", dut.blk, 0);
    irst = 1'b0;
    step(2);
    run_nominal("nom2");

    check("sb_drain", sbq.size(), 0);
    check("no_back2back", dbl, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
